// File: rtl/alu_pkg.sv
// Shared definitions for the vector execute-stage ALU: op encoding and
// signed saturation limits expressed as functions of lane width.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ZERO = 3'b000,
        OP_XOR  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_INC  = 3'b111
    } alu_op_t;

    // Limits are returned 64 bits wide; callers truncate to their lane width.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_lane.sv
// One combinational ALU lane: computes the op result, optional signed
// saturation on ADD/SUB, and the zero/negative/raw-overflow flags.
module alu_lane
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int INC_STEP = 4
) (
    input  alu_op_t            op,
    input  logic               sat_en,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               neg,
    output logic               ovf
);

    localparam int MSB = DATA_W - 1;
    localparam int CW  = (DATA_W > 32) ? DATA_W : 32;
    localparam logic [DATA_W-1:0] INC_V = DATA_W'(INC_STEP);
    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(max_pos(DATA_W));
    localparam logic [DATA_W-1:0] MIN_V = DATA_W'(min_neg(DATA_W));

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] inc_s;
    logic [DATA_W-1:0] prod_s;
    logic [DATA_W-1:0] res_s;
    logic [CW-1:0]     cnt_s;
    logic              shift_big_s;
    logic              add_ovf_s;
    logic              sub_ovf_s;
    logic              inc_ovf_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;
    assign inc_s  = a + INC_V;
    assign prod_s = a * b;

    // The shift count is the whole operand, so anything >= DATA_W flushes to zero.
    assign cnt_s       = CW'(b);
    assign shift_big_s = (cnt_s >= CW'(DATA_W));

    assign add_ovf_s = (a[MSB] == b[MSB])     && (sum_s[MSB]  != a[MSB]);
    assign sub_ovf_s = (a[MSB] != b[MSB])     && (diff_s[MSB] != a[MSB]);
    assign inc_ovf_s = (a[MSB] == INC_V[MSB]) && (inc_s[MSB]  != a[MSB]);

    // Op select; overflow direction follows the sign of a.
    always_comb begin
        res_s = '0;
        ovf   = 1'b0;
        case (op)
            OP_ZERO: res_s = '0;
            OP_XOR:  res_s = a ^ b;
            OP_ADD: begin
                ovf = add_ovf_s;
                if (sat_en && add_ovf_s) begin
                    res_s = a[MSB] ? MIN_V : MAX_V;
                end else begin
                    res_s = sum_s;
                end
            end
            OP_SUB: begin
                ovf = sub_ovf_s;
                if (sat_en && sub_ovf_s) begin
                    res_s = a[MSB] ? MIN_V : MAX_V;
                end else begin
                    res_s = diff_s;
                end
            end
            OP_MUL:  res_s = prod_s;
            OP_SHR: begin
                if (shift_big_s) begin
                    res_s = '0;
                end else begin
                    res_s = a >> b;
                end
            end
            OP_SHL: begin
                if (shift_big_s) begin
                    res_s = '0;
                end else begin
                    res_s = a << b;
                end
            end
            OP_INC: begin
                res_s = inc_s;
                ovf   = inc_ovf_s;
            end
            default: begin
                res_s = '0;
                ovf   = 1'b0;
            end
        endcase
    end

    assign result = res_s;
    assign zero   = (res_s == '0);
    assign neg    = res_s[MSB];

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage pipelined vector ALU with valid/ready handshake: S1 holds the
// request (broadcast already resolved), S2 holds per-lane results and flags.
module vector_alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LANES    = 4,
    parameter int INC_STEP = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic                      sat_en,
    input  logic                      bcast,
    input  logic [LANES*DATA_W-1:0]   opa,
    input  logic [LANES*DATA_W-1:0]   opb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   result,
    output logic [LANES-1:0]          zero_flag,
    output logic [LANES-1:0]          neg_flag,
    output logic [LANES-1:0]          ovf_flag
);

    localparam int VW = LANES * DATA_W;

    logic          s1_valid_q, s1_valid_d;
    alu_op_t       s1_op_q,    s1_op_d;
    logic          s1_sat_q,   s1_sat_d;
    logic [VW-1:0] s1_a_q,     s1_a_d;
    logic [VW-1:0] s1_b_q,     s1_b_d;

    logic             out_valid_q, out_valid_d;
    logic [VW-1:0]    result_q,    result_d;
    logic [LANES-1:0] zero_q,      zero_d;
    logic [LANES-1:0] neg_q,       neg_d;
    logic [LANES-1:0] ovf_q,       ovf_d;

    logic             adv_s;
    logic             accept_s;
    logic [VW-1:0]    opb_eff_s;
    logic [VW-1:0]    lane_res_s;
    logic [LANES-1:0] lane_zero_s;
    logic [LANES-1:0] lane_neg_s;
    logic [LANES-1:0] lane_ovf_s;

    assign adv_s     = !out_valid_q || out_ready;
    assign in_ready  = adv_s || !s1_valid_q;
    assign accept_s  = in_valid && in_ready;
    assign opb_eff_s = bcast ? {LANES{opb[DATA_W-1:0]}} : opb;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_lane #(
            .DATA_W   (DATA_W),
            .INC_STEP (INC_STEP)
        ) u_lane (
            .op     (s1_op_q),
            .sat_en (s1_sat_q),
            .a      (s1_a_q[i*DATA_W +: DATA_W]),
            .b      (s1_b_q[i*DATA_W +: DATA_W]),
            .result (lane_res_s[i*DATA_W +: DATA_W]),
            .zero   (lane_zero_s[i]),
            .neg    (lane_neg_s[i]),
            .ovf    (lane_ovf_s[i])
        );
    end

    // S1 next state: refill on accept, empty when it moves on with nothing new.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_sat_d   = s1_sat_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = alu_op_t'(op);
            s1_sat_d   = sat_en;
            s1_a_d     = opa;
            s1_b_d     = opb_eff_s;
        end else if (adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: data only changes when a valid S1 entry moves in.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        if (adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = lane_res_s;
                zero_d   = lane_zero_s;
                neg_d    = lane_neg_s;
                ovf_d    = lane_ovf_s;
            end else begin
                result_d = result_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ZERO;
            s1_sat_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= '0;
            neg_q       <= '0;
            ovf_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_sat_q    <= s1_sat_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero_flag = zero_q;
    assign neg_flag  = neg_q;
    assign ovf_flag  = ovf_q;

endmodule
